lcd_text_writer: RTL and testbench

- Parametrised 4-bit HD44780 text writer for displays with NUM_LINES×LINE_LENGTH characters.
- Snapshots a packed character buffer and an optional line mask on `start`.
- Optionally issues a clear-display command first, then, for each enabled line, one set-DDRAM-address command followed by LINE_LENGTH character writes.
- Drives the existing nibble transfer block through a send/done handshake; that block owns LCD_E and LCD_D timing.

---
 rtl/lcd_text_writer.sv | 177 +++++++++++++++++
 tb/tb_lcd_text_writer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_writer.sv
// HD44780 4-bit text refresher: snapshots text/mask on start, sends optional clear, then address + chars per line.
// First nibble two or three cycles after accept; each nibble waits indefinitely for cmd_done from the transfer block.
module lcd_text_writer #(
  parameter int LINE_LENGTH = 16,
  parameter int NUM_LINES   = 2,
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int T_HI_US     = 10,
  parameter int T_LO_US     = 53,
  parameter int T_CLR_US    = 2000,
  parameter int DELAY_W     = 21
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic                                  start,
  input  logic                                  clear_first,
  input  logic [NUM_LINES-1:0]                  line_mask,
  input  logic [8*LINE_LENGTH*NUM_LINES-1:0]    text,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  cmd_send,
  output logic [4:0]                            cmd_nibble,
  output logic [DELAY_W-1:0]                    cmd_delay,
  input  logic                                  cmd_done
);

  localparam int NUM_CHARS = LINE_LENGTH * NUM_LINES;
  localparam int US_CYC    = CLK_FREQ_HZ / 1000000;
  localparam logic [DELAY_W-1:0] DLY_HI  = DELAY_W'(US_CYC * T_HI_US);
  localparam logic [DELAY_W-1:0] DLY_LO  = DELAY_W'(US_CYC * T_LO_US);
  localparam logic [DELAY_W-1:0] DLY_CLR = DELAY_W'(US_CYC * T_CLR_US);
  localparam logic [5:0] LEN   = 6'(LINE_LENGTH);
  localparam logic [7:0] LEN_B = 8'(LINE_LENGTH);

  typedef enum logic [3:0] {
    IDLE, CLEAR, NEXT_LINE, SET_ADDR, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, NEXT_CHAR, FINISH
  } state_t;

  state_t                 state, next_state;
  logic [8*NUM_CHARS-1:0] text_q;
  logic [NUM_LINES-1:0]   mask_q;
  logic [2:0]             line_idx;
  logic [5:0]             char_idx;
  logic [7:0]             byte_q, byte_d;
  logic                   rs_q, rs_d;
  logic                   clr_cmd;
  logic                   accept;
  logic                   scan_found;
  logic [2:0]             scan_line;
  logic [7:0]             ch;
  logic [7:0]             base;

  // A start in the done cycle is deliberately refused.
  assign accept = (state == IDLE) && start && !done;

  always_comb begin
    scan_found = 1'b0;
    scan_line  = line_idx;
    for (int l = NUM_LINES - 1; l >= 0; l--) begin
      if (mask_q[l] && (3'(l) >= line_idx)) begin
        scan_found = 1'b1;
        scan_line  = 3'(l);
      end
    end

    ch = 8'h00;
    for (int l = 0; l < NUM_LINES; l++) begin
      for (int c = 0; c < LINE_LENGTH; c++) begin
        if (line_idx == 3'(l) && char_idx == 6'(c))
          ch = text_q[8*(NUM_CHARS-1-l*LINE_LENGTH-c) +: 8];
      end
    end

    case (line_idx)
      3'd0:    base = 8'h00;
      3'd1:    base = 8'h40;
      3'd2:    base = LEN_B;
      default: base = 8'h40 + LEN_B;
    endcase
  end

  always_comb begin
    next_state = state;
    byte_d     = byte_q;
    rs_d       = rs_q;
    case (state)
      IDLE:      if (accept) next_state = clear_first ? CLEAR : NEXT_LINE;
      CLEAR: begin
        byte_d     = 8'h01;
        rs_d       = 1'b0;
        next_state = SEND_HI;
      end
      NEXT_LINE: next_state = scan_found ? SET_ADDR : FINISH;
      SET_ADDR: begin
        byte_d     = 8'h80 | base;
        rs_d       = 1'b0;
        next_state = SEND_HI;
      end
      SEND_HI:   next_state = WAIT_HI;
      WAIT_HI:   if (cmd_done) next_state = SEND_LO;
      SEND_LO:   next_state = WAIT_LO;
      WAIT_LO:   if (cmd_done) next_state = NEXT_CHAR;
      NEXT_CHAR: begin
        if (clr_cmd) begin
          next_state = NEXT_LINE;
        end else if (char_idx < LEN) begin
          byte_d     = ch;
          rs_d       = 1'b1;
          next_state = SEND_HI;
        end else begin
          next_state = NEXT_LINE;
        end
      end
      FINISH:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      cmd_send   <= 1'b0;
      cmd_nibble <= '0;
      cmd_delay  <= '0;
      text_q     <= '0;
      mask_q     <= '0;
      line_idx   <= '0;
      char_idx   <= '0;
      byte_q     <= '0;
      rs_q       <= 1'b0;
      clr_cmd    <= 1'b0;
    end else begin
      busy     <= (next_state != IDLE);
      done     <= (state == FINISH);
      cmd_send <= (next_state == SEND_HI) || (next_state == SEND_LO);
      byte_q   <= byte_d;
      rs_q     <= rs_d;
      // Nibble and delay stay put until the next send, covering the whole handshake.
      if (next_state == SEND_HI) begin
        cmd_nibble <= {rs_d, byte_d[7:4]};
        cmd_delay  <= DLY_HI;
      end else if (next_state == SEND_LO) begin
        cmd_nibble <= {rs_q, byte_q[3:0]};
        cmd_delay  <= clr_cmd ? DLY_CLR : DLY_LO;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            text_q   <= text;
            mask_q   <= line_mask;
            line_idx <= '0;
            char_idx <= '0;
            clr_cmd  <= 1'b0;
          end
        end
        CLEAR:     clr_cmd <= 1'b1;
        NEXT_LINE: if (scan_found) line_idx <= scan_line;
        SET_ADDR: begin
          char_idx <= '0;
          clr_cmd  <= 1'b0;
        end
        NEXT_CHAR: begin
          if (clr_cmd)               clr_cmd  <= 1'b0;
          else if (char_idx < LEN)   char_idx <= char_idx + 6'd1;
          else                       line_idx <= line_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed bench for lcd_text_writer with a cmd_done responder emulating the nibble transfer block.
module tb_lcd_text_writer;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          start;
  logic          clear_first;
  logic [1:0]    line_mask;
  logic [255:0]  text;
  logic          busy, done, cmd_send;
  logic [4:0]    cmd_nibble;
  logic [20:0]   cmd_delay;
  logic          cmd_done;

  localparam logic [255:0] TXT = "HELLO WORLD     0123456789ABCDEF";

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_done   = 0;
  logic [4:0]  log_nib[$];
  logic [20:0] log_del[$];
  int          send_cyc[$];
  logic [4:0]  exp_nib[$];
  logic [20:0] exp_del[$];

  int resp_delay = 2;
  int resp_n     = 0;
  int long_at    = -1;
  int spur_at    = -1;
  int spur_req   = 0;
  int spur_ack   = 0;

  lcd_text_writer dut (
    .CLK(CLK), .RESET(RESET), .start(start), .clear_first(clear_first),
    .line_mask(line_mask), .text(text), .busy(busy), .done(done),
    .cmd_send(cmd_send), .cmd_nibble(cmd_nibble), .cmd_delay(cmd_delay),
    .cmd_done(cmd_done)
  );

  always #10 CLK = ~CLK;

  always @(negedge CLK) begin
    cyc++;
    if (cmd_send) begin
      log_nib.push_back(cmd_nibble);
      log_del.push_back(cmd_delay);
      send_cyc.push_back(cyc);
    end
    if (done) n_done++;
  end

  // Transfer-block model: answers each cmd_send after a programmable wait.
  initial begin : responder
    logic [4:0]  nib;
    logic [20:0] del;
    int          d;
    cmd_done = 1'b0;
    @(negedge CLK);
    forever begin
      if (cmd_send) begin
        nib = cmd_nibble;
        del = cmd_delay;
        d   = (resp_n == long_at) ? 5000 : resp_delay;
        if (resp_n == spur_at) begin
          cmd_done = 1'b1;
          @(negedge CLK);
          cmd_done = 1'b0;
        end
        resp_n++;
        repeat (d) @(negedge CLK);
        if (busy) begin
          n_checks++;
          if (cmd_nibble !== nib || cmd_delay !== del)
            $display("FAIL hold_stable: nibble %h delay %0d, required %h delay %0d", cmd_nibble, cmd_delay, nib, del);
          else
            n_pass++;
        end
        cmd_done = 1'b1;
        @(negedge CLK);
        cmd_done = 1'b0;
      end else if (spur_req != spur_ack) begin
        spur_ack++;
        cmd_done = 1'b1;
        @(negedge CLK);
        cmd_done = 1'b0;
      end else begin
        @(negedge CLK);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal;
  end

  task automatic build_exp(input logic clr, input logic [1:0] mask, input logic [255:0] txt);
    logic [7:0] b;
    exp_nib.delete();
    exp_del.delete();
    if (clr) begin
      exp_nib.push_back(5'h00); exp_del.push_back(21'd500);
      exp_nib.push_back(5'h01); exp_del.push_back(21'd100000);
    end
    for (int l = 0; l < 2; l++) begin
      if (mask[l]) begin
        b = (l == 0) ? 8'h80 : 8'hC0;
        exp_nib.push_back({1'b0, b[7:4]}); exp_del.push_back(21'd500);
        exp_nib.push_back({1'b0, b[3:0]}); exp_del.push_back(21'd2650);
        for (int c = 0; c < 16; c++) begin
          b = txt[8*(31-(l*16+c)) +: 8];
          exp_nib.push_back({1'b1, b[7:4]}); exp_del.push_back(21'd500);
          exp_nib.push_back({1'b1, b[3:0]}); exp_del.push_back(21'd2650);
        end
      end
    end
  endtask

  function automatic int first_diff(input int base);
    for (int i = 0; i < exp_nib.size(); i++) begin
      if (base + i >= log_nib.size()) return i;
      if (log_nib[base+i] !== exp_nib[i] || log_del[base+i] !== exp_del[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [4:0] got_nib(input int idx);
    return (idx < log_nib.size()) ? log_nib[idx] : 5'h1f;
  endfunction

  task automatic pulse_start();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge CLK);
      #1;
      if (n_done > prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; start = 1'b0; clear_first = 1'b0; line_mask = 2'b00; text = '0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({busy, done, cmd_send} !== 3'b000) $display("FAIL reset_ctrl: busy/done/send %b, required 000", {busy, done, cmd_send});
    else n_pass++;
    n_checks++;
    if (cmd_nibble !== 5'h00 || cmd_delay !== 21'd0) $display("FAIL reset_cmd: nibble %h delay %0d, required 0 0", cmd_nibble, cmd_delay);
    else n_pass++;
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (busy !== 1'b0 || cmd_send !== 1'b0) $display("FAIL idle_quiet: busy %b send %b, required 0 0", busy, cmd_send);
    else n_pass++;
  endtask

  task automatic test_two_lines();
    int base, prev, d;
    bit ok;
    base = log_nib.size(); prev = n_done;
    text = TXT; line_mask = 2'b11; clear_first = 1'b0;
    pulse_start();
    wait_done(prev, 3000, ok);
    n_checks++;
    if (!ok) $display("FAIL two_lines_done: done seen %0d, required 1", ok);
    else n_pass++;
    repeat (3) @(negedge CLK);
    #1;
    n_checks++;
    if (log_nib.size() - base != 68) $display("FAIL two_lines_count: %0d sends, required 68", log_nib.size() - base);
    else n_pass++;
    n_checks++;
    if (n_done - prev != 1 || busy !== 1'b0) $display("FAIL two_lines_end: done pulses %0d busy %b, required 1 0", n_done - prev, busy);
    else n_pass++;
    n_checks++;
    if (got_nib(base) !== 5'h08 || got_nib(base+1) !== 5'h00 || got_nib(base+2) !== 5'h14 || got_nib(base+3) !== 5'h18)
      $display("FAIL two_lines_head: %h %h %h %h, required 08 00 14 18", got_nib(base), got_nib(base+1), got_nib(base+2), got_nib(base+3));
    else n_pass++;
    n_checks++;
    if (got_nib(base+34) !== 5'h0C || got_nib(base+35) !== 5'h00 || got_nib(base+36) !== 5'h13 || got_nib(base+37) !== 5'h10)
      $display("FAIL two_lines_line1: %h %h %h %h, required 0C 00 13 10", got_nib(base+34), got_nib(base+35), got_nib(base+36), got_nib(base+37));
    else n_pass++;
    build_exp(1'b0, 2'b11, TXT);
    d = first_diff(base);
    n_checks++;
    if (d >= 0) $display("FAIL two_lines_seq: nibble %0d is %h, required %h/%0d", d, got_nib(base+d), exp_nib[d], exp_del[d]);
    else n_pass++;
  endtask

  task automatic test_clear_line1();
    int base, prev, d;
    bit ok;
    base = log_nib.size(); prev = n_done;
    text = TXT; line_mask = 2'b10; clear_first = 1'b1;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || cmd_send !== 1'b0) $display("FAIL clr_accept: busy %b send %b, required 1 0", busy, cmd_send);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (cmd_send !== 1'b1 || cmd_nibble !== 5'h00 || cmd_delay !== 21'd500)
      $display("FAIL clr_first_send: send %b nibble %h delay %0d, required 1 00 500", cmd_send, cmd_nibble, cmd_delay);
    else n_pass++;
    wait_done(prev, 3000, ok);
    repeat (2) @(negedge CLK);
    #1;
    n_checks++;
    if (!ok || log_nib.size() - base != 36) $display("FAIL clr_count: done %0d sends %0d, required 1 36", ok, log_nib.size() - base);
    else n_pass++;
    n_checks++;
    if (log_del.size() < base + 2 || log_del[base+1] !== 21'd100000 || got_nib(base+1) !== 5'h01)
      $display("FAIL clr_delay: second nibble %h, required 01 with delay 100000", got_nib(base+1));
    else n_pass++;
    n_checks++;
    if (got_nib(base+2) !== 5'h0C || got_nib(base+3) !== 5'h00) $display("FAIL clr_addr: %h %h, required 0C 00", got_nib(base+2), got_nib(base+3));
    else n_pass++;
    build_exp(1'b1, 2'b10, TXT);
    d = first_diff(base);
    n_checks++;
    if (d >= 0) $display("FAIL clr_seq: nibble %0d is %h, required %h/%0d", d, got_nib(base+d), exp_nib[d], exp_del[d]);
    else n_pass++;
  endtask

  task automatic test_empty();
    int base, prev;
    base = log_nib.size(); prev = n_done;
    line_mask = 2'b00; clear_first = 1'b0;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) $display("FAIL empty_c1: busy %b done %b, required 1 0", busy, done);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) $display("FAIL empty_c2: busy %b done %b, required 1 0", busy, done);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1) $display("FAIL empty_c3: busy %b done %b, required 0 1", busy, done);
    else n_pass++;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL start_in_done: busy %b done %b, required 0 0", busy, done);
    else n_pass++;
    repeat (2) @(negedge CLK);
    #1;
    n_checks++;
    if (log_nib.size() != base || n_done - prev != 1) $display("FAIL empty_totals: sends %0d done %0d, required 0 1", log_nib.size() - base, n_done - prev);
    else n_pass++;
  endtask

  task automatic test_snapshot();
    int base, prev, d;
    bit ok;
    base = log_nib.size(); prev = n_done;
    text = TXT; line_mask = 2'b11; clear_first = 1'b0;
    pulse_start();
    for (int i = 0; i < 500 && log_nib.size() < base + 10; i++) begin
      @(negedge CLK);
      #1;
    end
    text = {32{8'h3F}}; line_mask = 2'b01; clear_first = 1'b1;
    pulse_start();
    wait_done(prev, 3000, ok);
    repeat (20) @(negedge CLK);
    #1;
    n_checks++;
    if (!ok || n_done - prev != 1) $display("FAIL snap_done: done pulses %0d, required 1", n_done - prev);
    else n_pass++;
    n_checks++;
    if (log_nib.size() - base != 68) $display("FAIL snap_count: %0d sends, required 68", log_nib.size() - base);
    else n_pass++;
    build_exp(1'b0, 2'b11, TXT);
    d = first_diff(base);
    n_checks++;
    if (d >= 0) $display("FAIL snap_seq: nibble %0d is %h, required %h/%0d", d, got_nib(base+d), exp_nib[d], exp_del[d]);
    else n_pass++;
    text = TXT; clear_first = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base, prev;
    bit ok;
    resp_delay = 20;
    base = log_nib.size();
    text = TXT; line_mask = 2'b11; clear_first = 1'b0;
    pulse_start();
    for (int i = 0; i < 2000 && log_nib.size() < base + 14; i++) begin
      @(negedge CLK);
      #1;
    end
    @(negedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || cmd_send !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_async: busy %b send %b done %b, required 0 0 0", busy, cmd_send, done);
    else n_pass++;
    n_checks++;
    if (log_nib.size() - base != 14) $display("FAIL rst_point: %0d sends before reset, required 14", log_nib.size() - base);
    else n_pass++;
    repeat (40) @(negedge CLK);
    #1;
    n_checks++;
    if (log_nib.size() - base != 14) $display("FAIL rst_quiet: %0d sends after reset, required 14", log_nib.size() - base);
    else n_pass++;
    @(negedge CLK);
    RESET = 1'b0;
    resp_delay = 2;
    repeat (2) @(negedge CLK);
    #1;
    base = log_nib.size(); prev = n_done;
    line_mask = 2'b01;
    pulse_start();
    wait_done(prev, 3000, ok);
    n_checks++;
    if (!ok || got_nib(base) !== 5'h08 || got_nib(base+1) !== 5'h00 || log_nib.size() - base != 34)
      $display("FAIL rst_restart: done %0d first %h %h sends %0d, required 1 08 00 34", ok, got_nib(base), got_nib(base+1), log_nib.size() - base);
    else n_pass++;
  endtask

  task automatic test_spurious();
    int base, prev, d;
    bit ok;
    base = log_nib.size(); prev = n_done;
    spur_req++;
    repeat (4) @(negedge CLK);
    #1;
    n_checks++;
    if (busy !== 1'b0 || log_nib.size() != base) $display("FAIL spur_idle: busy %b sends %0d, required 0 0", busy, log_nib.size() - base);
    else n_pass++;
    text = TXT; line_mask = 2'b01; clear_first = 1'b0;
    spur_at = resp_n;
    long_at = resp_n;
    pulse_start();
    wait_done(prev, 12000, ok);
    repeat (2) @(negedge CLK);
    #1;
    n_checks++;
    if (!ok || log_nib.size() - base != 34) $display("FAIL spur_count: done %0d sends %0d, required 1 34", ok, log_nib.size() - base);
    else n_pass++;
    n_checks++;
    if (send_cyc.size() < base + 2 || send_cyc[base+1] - send_cyc[base] != 5002)
      $display("FAIL spur_wait: gap %0d cycles, required 5002", (send_cyc.size() < base + 2) ? -1 : send_cyc[base+1] - send_cyc[base]);
    else n_pass++;
    build_exp(1'b0, 2'b01, TXT);
    d = first_diff(base);
    n_checks++;
    if (d >= 0) $display("FAIL spur_seq: nibble %0d is %h, required %h/%0d", d, got_nib(base+d), exp_nib[d], exp_del[d]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_two_lines();
    test_clear_line1();
    test_empty();
    test_snapshot();
    test_reset_mid();
    test_spurious();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
